// File: rtl/ddr_loopback_checker.sv
// rtl/ddr_loopback_checker.sv - DDR write/read-back pattern tester for one DDR channel.
// Optional first-error address capture is enabled by defining DDR_LOOPBACK_ERR_LOG_EN.
module ddr_loopback_checker #(
   parameter int                DATA_W    = 512,
   parameter int                ADDR_W    = 32,
   parameter int                SIZE_W    = 8,
   parameter int                BURST_LEN = 32,
   parameter int                BURST_NUM = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [31:0]       seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [SIZE_W-1:0] out_size,
   output logic              out_addr_valid,
   input  logic              out_addr_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] in_addr,
   output logic [SIZE_W-1:0] in_size,
   output logic              in_addr_valid,
   input  logic              in_addr_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready
);

   localparam int                WORDS       = DATA_W / 32;
   localparam int                BI_W        = (BURST_NUM > 1) ? $clog2(BURST_NUM) : 1;
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * (DATA_W / 8));
   localparam logic [SIZE_W-1:0] LAST_BEAT   = SIZE_W'(BURST_LEN - 1);
   localparam logic [BI_W-1:0]   LAST_BURST  = BI_W'(BURST_NUM - 1);
   localparam logic [31:0]       LFSR_TAPS   = 32'h8020_0003;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_ADDR = 3'd1;
   localparam logic [2:0] ST_WR_DATA = 3'd2;
   localparam logic [2:0] ST_RD_ADDR = 3'd3;
   localparam logic [2:0] ST_RD_DATA = 3'd4;
   localparam logic [2:0] ST_FIN     = 3'd5;

   logic [2:0]        state;
   logic [1:0]        mode_q;
   logic [31:0]       seed_q;
   logic [31:0]       gen;
   logic [31:0]       gen_nxt;
   logic [SIZE_W-1:0] beat_idx;
   logic [BI_W-1:0]   burst_idx;
   logic              cmp_valid;
   logic              cmp_miss;
   logic [15:0]       err_cnt_nxt;
   logic              start_ok;

   function automatic logic [31:0] gen_init(input logic [1:0] m, input logic [31:0] s);
      return (m == 2'd2 && s == 32'd0) ? 32'd1 : s;
   endfunction

   // Every pattern is derived from the previous word, so one 32-bit register is the whole generator.
   function automatic logic [31:0] gen_step(input logic [1:0] m, input logic [31:0] w);
      logic [31:0] r;
      case (m)
         2'd0:    r = w;
         2'd1:    r = w + 32'd1;
         2'd2:    r = (w >> 1) ^ (w[0] ? LFSR_TAPS : 32'd0);
         default: r = {w[30:0], w[31]};
      endcase
      return r;
   endfunction

   assign gen_nxt  = gen_step(mode_q, gen);
   assign start_ok = (state == ST_IDLE) && start && !done;

   always_comb begin
      err_cnt_nxt = err_cnt;
      if (cmp_valid && cmp_miss && err_cnt != 16'hFFFF)
         err_cnt_nxt = err_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_size <= SIZE_W'(BURST_LEN);
         in_size  <= SIZE_W'(BURST_LEN);
      end else begin
         out_size <= SIZE_W'(BURST_LEN);
         in_size  <= SIZE_W'(BURST_LEN);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         mode_q         <= 2'd0;
         seed_q         <= 32'd0;
         gen            <= 32'd0;
         beat_idx       <= '0;
         burst_idx      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_cnt        <= 16'd0;
         cmp_valid      <= 1'b0;
         cmp_miss       <= 1'b0;
         out_addr       <= '0;
         out_addr_valid <= 1'b0;
         out_data       <= '0;
         out_valid      <= 1'b0;
         in_addr        <= '0;
         in_addr_valid  <= 1'b0;
         in_ready       <= 1'b0;
      end else begin
         done      <= 1'b0;
         cmp_valid <= 1'b0;
         err_cnt   <= err_cnt_nxt;
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  mode_q         <= mode;
                  seed_q         <= seed;
                  gen            <= gen_init(mode, seed);
                  beat_idx       <= '0;
                  burst_idx      <= '0;
                  err_cnt        <= 16'd0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  out_addr       <= BASE_ADDR;
                  out_addr_valid <= 1'b1;
                  state          <= ST_WR_ADDR;
               end
            end
            ST_WR_ADDR: begin
               if (out_addr_ready) begin
                  out_addr_valid <= 1'b0;
                  out_valid      <= 1'b1;
                  out_data       <= {WORDS{gen}};
                  state          <= ST_WR_DATA;
               end
            end
            ST_WR_DATA: begin
               if (out_ready) begin
                  gen      <= gen_nxt;
                  out_data <= {WORDS{gen_nxt}};
                  beat_idx <= beat_idx + SIZE_W'(1);
                  if (beat_idx == LAST_BEAT) begin
                     out_valid <= 1'b0;
                     beat_idx  <= '0;
                     if (burst_idx == LAST_BURST) begin
                        // Read phase replays the same sequence from the latched seed.
                        burst_idx     <= '0;
                        gen           <= gen_init(mode_q, seed_q);
                        in_addr       <= BASE_ADDR;
                        in_addr_valid <= 1'b1;
                        state         <= ST_RD_ADDR;
                     end else begin
                        burst_idx      <= burst_idx + BI_W'(1);
                        out_addr       <= out_addr + BURST_BYTES;
                        out_addr_valid <= 1'b1;
                        state          <= ST_WR_ADDR;
                     end
                  end
               end
            end
            ST_RD_ADDR: begin
               if (in_addr_ready) begin
                  in_addr_valid <= 1'b0;
                  in_ready      <= 1'b1;
                  state         <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (in_valid) begin
                  cmp_valid <= 1'b1;
                  cmp_miss  <= (in_data != {WORDS{gen}});
                  gen       <= gen_nxt;
                  beat_idx  <= beat_idx + SIZE_W'(1);
                  if (beat_idx == LAST_BEAT) begin
                     in_ready <= 1'b0;
                     beat_idx <= '0;
                     if (burst_idx == LAST_BURST) begin
                        burst_idx <= '0;
                        state     <= ST_FIN;
                     end else begin
                        burst_idx     <= burst_idx + BI_W'(1);
                        in_addr       <= in_addr + BURST_BYTES;
                        in_addr_valid <= 1'b1;
                        state         <= ST_RD_ADDR;
                     end
                  end
               end
            end
            ST_FIN: begin
               // The last compare lands in err_cnt on this same edge.
               done  <= 1'b1;
               pass  <= (err_cnt_nxt == 16'd0);
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef DDR_LOOPBACK_ERR_LOG_EN
   localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

   logic [ADDR_W-1:0] beat_addr;
   logic [ADDR_W-1:0] cmp_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_addr      <= '0;
         cmp_addr       <= '0;
         first_err_addr <= '0;
      end else begin
         if (state == ST_RD_ADDR && in_addr_ready)
            beat_addr <= in_addr;
         else if (state == ST_RD_DATA && in_valid)
            beat_addr <= beat_addr + BEAT_BYTES;
         if (state == ST_RD_DATA && in_valid)
            cmp_addr <= beat_addr;
         if (start_ok)
            first_err_addr <= '0;
         else if (cmp_valid && cmp_miss && err_cnt == 16'd0)
            first_err_addr <= cmp_addr;
      end
   end
`else
   assign first_err_addr = '0;
`endif

endmodule

// File: doc/ddr_loopback_checker.md
# ddr_loopback_checker

- Self-contained, synthesizable DDR write/read-back tester for one DDR port of the accelerator.
- On `start` it writes `BURST_NUM` bursts of `BURST_LEN` beats from a selectable pattern generator. It then reads the same region back and compares every beat against the regenerated pattern.
- It reports pass/fail, a saturating error count and, optionally, the first failing address.
- One instance sits on each DDR channel's in/out ports in bring-up builds, in place of the compute core.

## Interface

**Parameters**
- `DATA_W`, 512: DDR beat width in bits; multiple of 32.
- `ADDR_W`, 32: DDR byte-address width.
- `SIZE_W`, 8: burst-size field width.
- `BURST_LEN`, 32: beats per burst; must be less than 2^SIZE_W.
- `BURST_NUM`, 16: bursts per test pass; at least 1.
- `BASE_ADDR`, 0: byte address of the first burst.

**Ports**
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low. `rst`=0 resets the block.
- `start` in 1: one-cycle request to begin a pass; ignored while `busy`.
- `mode` in 2: pattern select, sampled at `start`.
- `seed` in 32: pattern seed, sampled at `start`.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at end of pass.
- `pass` out 1: last pass had zero errors; held until next `start`.
- `err_cnt` out 16: mismatching beats in the last pass; saturates at 0xFFFF.
- `first_err_addr` out ADDR_W: byte address of the first mismatching beat.
- `out_addr`, `out_size`, `out_addr_valid` out; `out_addr_ready` in: write-address channel.
- `out_data` out DATA_W, `out_valid` out, `out_ready` in: write-data channel.
- `in_addr`, `in_size`, `in_addr_valid` out; `in_addr_ready` in: read-address channel.
- `in_data` in DATA_W, `in_valid` in, `in_ready` out: read-data channel.

## Operation

**States:** IDLE → WR_ADDR → WR_DATA → (next burst: WR_ADDR | last: RD_ADDR) → RD_DATA → (next burst: RD_ADDR | last: FIN) → IDLE.

**IDLE**
- On `start`: latch `mode` and `seed`.
- Clear `err_cnt`, `pass`, `first_err_addr`, burst index and beat index.
- Load the generator with `seed`.

**Addressing**
- Burst address = `BASE_ADDR + burst_idx*BURST_LEN*(DATA_W/8)`, modulo 2^ADDR_W (wraps silently).
- `out_size` = `in_size` = `BURST_LEN`.

**WR_ADDR**
- Drive `out_addr_valid` until `out_addr_ready`, then go to WR_DATA.

**WR_DATA**
- Present the pattern beat with `out_valid`.
- Advance the generator and beat index only on `out_valid && out_ready`.
- After `BURST_LEN` accepted beats, increment `burst_idx`.

**Read phase**
- Before the first RD_ADDR, reload the generator with the latched seed and reset `burst_idx`.

**RD_ADDR**
- Same handshake as WR_ADDR on the `in_addr_*` channel.

**RD_DATA**
- `in_ready`=1.
- Each `in_valid && in_ready` beat is compared with the generator output. Mismatch: `err_cnt`+1, saturating. Then the generator advances.
- After `BURST_LEN` beats, increment `burst_idx`.

**FIN**
- Pulse `done` for one cycle.
- `pass` = (`err_cnt`==0).
- Return to IDLE.

**Patterns**
- Each is a 32-bit word replicated DATA_W/32 times.
- 0: constant `seed`.
- 1: global beat counter `seed + n`.
- 2: 32-bit Galois LFSR, polynomial 0x80200003, advancing once per beat. A seed of 0 is forced to 1.
- 3: walking one, `seed` rotated left by n mod 32.
- Beat n counts from 0 across all bursts.

## Timing

**Reset values**
- All `*_valid`, `in_ready`, `busy`, `done`, `pass` = 0.
- `err_cnt` = 0, `first_err_addr` = 0.
- `out_addr`, `in_addr`, `out_data` = 0; sizes = `BURST_LEN`.

**Registered outputs and handshake rules**
- All outputs are registered.
- A valid, once raised, holds and keeps its payload stable until the same-edge handshake with ready.
- Back-to-back beats: one beat per cycle while ready=1, with no bubble inside a burst.
- One idle cycle is allowed between an address handshake and the first data beat.

**Latency**
- `start` to `out_addr_valid`: 1 cycle.
- Last read beat accepted to `done`: 2 cycles. `err_cnt` and `pass` are valid in the same cycle as `done`.

**Boundary conditions**
- `in_valid` while `in_ready`=0 is ignored.
- `start` in the same cycle as `done`: ignored.
- Reset mid-pass: valids drop immediately (asynchronously), the FSM returns to IDLE, and no `done` is produced.
- Error-count overflow: holds at 0xFFFF.

## Configuration

`DDR_LOOPBACK_ERR_LOG_EN`
- **Defined:** `first_err_addr` latches the byte address (burst address + beat×DATA_W/8) of the first mismatch in a pass and holds it until the next `start`.
- **Undefined:** `first_err_addr` is constant 0 and the capture logic is absent.

## Test plan

- **Ideal memory, always ready:** model with ready=1 and 1-cycle read return; BURST_LEN=4, BURST_NUM=2, mode 1, seed 0x10 → written words 0x10..0x17; `done` with `pass`=1, `err_cnt`=0.
- **Backpressure:** random 50% ready on all channels, mode 2, seed 0 → LFSR starts at 1; no beat lost or duplicated; `pass`=1.
- **Fault injection:** memory flips bit 0 of beat 5, mode 0, seed 0xA5A5A5A5 → `err_cnt`=1, `pass`=0. With `DDR_LOOPBACK_ERR_LOG_EN`: `first_err_addr`=BASE_ADDR+5×64.
- **Saturation:** memory returns all zeros for 70000 beats (BURST_LEN=250, BURST_NUM=280) → `err_cnt`=0xFFFF.
- **Address wrap:** BASE_ADDR=0xFFFFFF80, DATA_W=512, BURST_LEN=2 → second burst address = 0x00000000.
- **Reset mid-pass:** `rst`=0 during WR_DATA → all valids 0 in the same cycle; `busy`=0; no `done`; a following `start` runs a full pass with `pass`=1.
